// File: rtl/div_pkg.sv
// Shared types and constants for the 32-bit signed restoring divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_STEPS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Two's-complement negate when neg is set; 0x80000000 maps to itself.
  function automatic logic [DIV_WIDTH-1:0] cond_neg(input logic [DIV_WIDTH-1:0] v,
                                                    input logic                 neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  // Unsigned magnitude of a signed operand.
  function automatic logic [DIV_WIDTH-1:0] mag(input logic [DIV_WIDTH-1:0] v);
    return cond_neg(v, v[DIV_WIDTH-1]);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, subtract divisor if it fits.
// Latency: combinational.
// Backpressure: none; evaluated every cycle, the caller decides when to register it.
module div_step
  import div_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] rem_in,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic                 next_bit,
  output logic [DIV_WIDTH-1:0] rem_out,
  output logic                 q_bit
);

  // One extra bit so the comparison is exact even though rem_in < divisor keeps the top bit clear.
  logic [DIV_WIDTH:0] shifted;

  // Trial subtraction; the difference always fits because it is below the divisor.
  always_comb begin
    shifted = {rem_in, next_bit};
    q_bit   = (shifted >= {1'b0, divisor});
    rem_out = q_bit ? (shifted[DIV_WIDTH-1:0] - divisor) : shifted[DIV_WIDTH-1:0];
  end

endmodule

// File: rtl/division.sv
// Signed 32-bit divider (restoring, one bit per cycle): LO = quotient, HI = remainder.
// Latency: done in the 34th cycle after capture; 1 cycle when B = 0.
// Backpressure: none; enable is only sampled in IDLE, busy reports an operation in flight.
module division
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  div_state_e                 state_q, state_d;
  logic [5:0]                 cnt_q, cnt_d;
  logic [2*DIV_WIDTH-1:0]     sr_q, sr_d;      // {remainder, quotient}
  logic [DIV_WIDTH-1:0]       dvd_q, dvd_d;    // dividend magnitude, consumed MSB first
  logic [DIV_WIDTH-1:0]       dvs_q, dvs_d;    // divisor magnitude
  logic                       qneg_q, qneg_d;
  logic                       rneg_q, rneg_d;
  logic [DIV_WIDTH-1:0]       hi_q, hi_d;
  logic [DIV_WIDTH-1:0]       lo_q, lo_d;
  logic                       dz_q, dz_d;

  logic [DIV_WIDTH-1:0]       rem_nxt;
  logic                       q_bit;

  div_step u_step (
    .rem_in   (sr_q[2*DIV_WIDTH-1:DIV_WIDTH]),
    .divisor  (dvs_q),
    .next_bit (dvd_q[DIV_WIDTH-1]),
    .rem_out  (rem_nxt),
    .q_bit    (q_bit)
  );

  // FSM next state plus datapath: capture, iterate, sign-fix, report.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          dvd_d   = mag(A);
          dvs_d   = mag(B);
          qneg_d  = A[DIV_WIDTH-1] ^ B[DIV_WIDTH-1];
          rneg_d  = A[DIV_WIDTH-1];
          sr_d    = '0;
          cnt_d   = '0;
          dz_d    = (B == '0);
          state_d = (B == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        sr_d  = {rem_nxt, sr_q[DIV_WIDTH-2:0], q_bit};
        dvd_d = dvd_q << 1;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(DIV_STEPS - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        lo_d    = cond_neg(sr_q[DIV_WIDTH-1:0], qneg_q);
        hi_d    = cond_neg(sr_q[2*DIV_WIDTH-1:DIV_WIDTH], rneg_q);
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end

  assign HI       = hi_q;
  assign LO       = lo_q;
  assign div_zero = dz_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

endmodule
